pc_gen_param: RTL and testbench
===============================

Name: pc_gen_param

Overview:
- Parametrised next-generation fetch PC generator for the mini_cpu pipeline.
- Holds the architectural fetch PC and presents it to the IF stage with a valid/ready handshake.
- Applies prioritised redirects: trap, jump, taken branch.
- A redirect arriving during a stall is held in a pending register and applied once the stall drops, so it is never lost.

Parameters:
- XLEN, 32, width of PC and all target buses.
- RESET_VEC, 32'h0000_0000, PC value loaded by reset.
- INSTR_BYTES, 4, sequential increment and alignment requirement; legal values 2 or 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard stall; PC holds.
- br_taken_i  in  1  EX-stage conditional branch resolved taken.
- br_target_i  in  XLEN  branch target.
- jump_i  in  1  EX-stage jal/jalr.
- jump_target_i  in  XLEN  jump target from ALU; bit 0 is forced to 0 before use.
- trap_i  in  1  trap/exception request.
- trap_vec_i  in  XLEN  trap handler address.
- fetch_ready_i  in  1  IF stage accepts pc_o this cycle.
- pc_o  out  XLEN  current fetch PC.
- pc_valid_o  out  1  pc_o is valid for fetch.
- redirect_o  out  1  one-cycle pulse; a redirect was applied this edge; IF/ID must flush.
- misalign_o  out  1  one-cycle pulse; a non-trap target was misaligned and dropped.
- bad_addr_o  out  XLEN  offending target captured on misalign; holds until the next misalign.

Behaviour:
- Reset, when reset=1 at an edge:
  - pc_o = RESET_VEC, pc_valid_o = 0, redirect_o = 0, misalign_o = 0, bad_addr_o = 0.
  - Pending register cleared; state = BOOT.
- States:
  - BOOT: lasts exactly one cycle after reset deasserts, then RUN. pc_valid_o = 0. Redirects seen in BOOT go to the pending register.
  - RUN: pc_valid_o = 1.
- Redirect selection, same cycle: trap_i > jump_i > br_taken_i. The selected target is the incoming redirect.
- Alignment check for non-trap targets: target mod INSTR_BYTES != 0 means misaligned.
  - The redirect is discarded.
  - misalign_o pulses next cycle and bad_addr_o is loaded.
  - The PC follows the normal sequential/stall rules.
  - Traps are never checked.
- RUN, stall_i = 0, in this order of priority:
  - Pending valid: pc <= pending target, pending cleared, redirect_o = 1. Any same-cycle incoming redirect overrides pending instead (newer wins, subject to the trap rule below).
  - Otherwise, incoming redirect: pc <= target, redirect_o = 1. This ignores fetch_ready_i.
  - Otherwise, if fetch_ready_i = 1: pc <= pc + INSTR_BYTES, modulo 2^XLEN (wrap from all-ones region to 0).
  - Otherwise: hold.
- RUN or BOOT, stall_i = 1:
  - pc holds; redirect_o = 0.
  - An incoming redirect writes the pending register.
  - A non-trap redirect never overwrites a pending trap. A trap always overwrites.
- Latency: redirect input to pc_o = 1 cycle when unstalled; otherwise 1 cycle after stall_i falls.
- Reset mid-stall or with pending valid: everything is discarded and the reset values above apply.
- redirect_o and misalign_o are registered. They can never both be 1 for the same redirect.

Optional Feature:
- Macro: PC_GEN_PERF_EN.
- Defined:
  - Adds outputs redirect_cnt_o [31:0] and stall_cnt_o [31:0].
  - redirect_cnt_o increments on every cycle where redirect_o is set.
  - stall_cnt_o increments on every RUN cycle with stall_i = 1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Boot and sequential fetch:
  - Stimulus: RESET_VEC = 32'h0000_1000, deassert reset, fetch_ready_i = 1.
  - Response: cycle 0 pc_valid_o = 0. Then pc_o = 1000, 1004, 1008 with pc_valid_o = 1.
- Fetch backpressure:
  - Stimulus: fetch_ready_i = 0 for 3 cycles at pc 32'h20.
  - Response: pc_o stays 32'h20, then advances to 32'h24 when ready returns.
- Same-cycle priority:
  - Stimulus: trap_i, jump_i and br_taken_i all asserted with trap_vec_i = 32'h100, jump 32'h200, branch 32'h300.
  - Response: next pc_o = 32'h100, redirect_o = 1 for exactly one cycle.
- Stall with pending redirects:
  - Stimulus: stall_i = 1 for 4 cycles; br_taken_i to 32'h40 in stall cycle 1; trap to 32'h80 in cycle 2; jump to 32'hC0 in cycle 3.
  - Response: pc_o held during the stall, then pc_o = 32'h80 one cycle after stall_i falls.
- Misaligned jump:
  - Stimulus: jump_target_i = 32'h0000_0103, INSTR_BYTES = 4.
  - Response: bit 0 is cleared to give 32'h102, which is still misaligned. The jump is dropped, misalign_o pulses, bad_addr_o = 32'h102, and the PC continues sequentially.
- Wrap and reset mid-pending:
  - Stimulus: pc = 32'hFFFF_FFFC with fetch_ready_i = 1.
  - Response: pc_o = 0.
  - Stimulus: redirect captured during a stall, then reset asserted.
  - Response: pc_o = RESET_VEC and the pending redirect is never applied.
  - With PC_GEN_PERF_EN defined: both counters read 0 after reset.

Source files
------------

// File: rtl/pc_gen_param.sv
// Fetch PC generator: sequential fetch with prioritised trap/jump/branch redirects and a pending slot for redirects seen while stalled.
// Latency: redirect input to pc_o is 1 cycle when unstalled, else 1 cycle after the stall (or BOOT cycle) ends.
// Backpressure: fetch_ready_i=0 holds the PC; stall_i=1 holds the PC and parks any redirect in the pending slot.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall_i             hazard stall, PC holds
//   br_taken_i/target   taken branch redirect (lowest priority)
//   jump_i/target       jal/jalr redirect, target bit 0 cleared before use
//   trap_i/trap_vec_i   trap redirect (highest priority, never alignment-checked)
//   fetch_ready_i       IF stage accepts pc_o this cycle
//   pc_o, pc_valid_o    current fetch PC and its valid flag
//   redirect_o          registered pulse: a redirect was applied at the last edge (flush IF/ID)
//   misalign_o          registered pulse: a non-trap target was misaligned and dropped
//   bad_addr_o          last misaligned target, held until the next misalign
//   redirect_cnt_o, stall_cnt_o   saturating perf counters, present only with PC_GEN_PERF_EN defined
//
// Build option: define PC_GEN_PERF_EN to add the perf counter outputs.

module pc_gen_param #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            redirect_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o
`ifdef PC_GEN_PERF_EN
    ,
    output logic [31:0]     redirect_cnt_o,
    output logic [31:0]     stall_cnt_o
`endif
);

    // INSTR_BYTES is 2 or 4, so the low-bit mask is a cheap alignment test.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] BIT0_CLR   = ~XLEN'(1);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Parked redirect; trap flag lets a trap protect itself from later non-trap redirects.
    typedef struct packed {
        logic            vld;
        logic            trap;
        logic [XLEN-1:0] tgt;
    } pend_t;

    state_t          state_q;
    state_t          state_nxt;
    logic            in_run;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    pend_t           pend_q;
    pend_t           pend_nxt;
    logic            redirect_q;
    logic            misalign_q;
    logic [XLEN-1:0] bad_addr_q;

    logic            in_vld;
    logic [XLEN-1:0] in_tgt;
    logic            in_misal;
    logic            in_ok;
    logic            in_beats_pend;
    logic            hold;
    logic            take_in;
    logic            take_pend;

    // ------------------------------------------------------------------
    // FSM: BOOT lasts one cycle after reset, then RUN forever.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        in_run     = 1'b0;
        pc_valid_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_run     = 1'b1;
                pc_valid_o = 1'b1;
            end
            default: begin
                in_run     = 1'b0;
                pc_valid_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Incoming redirect selection and alignment check.
    // ------------------------------------------------------------------
    always_comb begin
        in_vld = trap_i | jump_i | br_taken_i;
        if (trap_i) begin
            in_tgt = trap_vec_i;
        end else if (jump_i) begin
            in_tgt = jump_target_i & BIT0_CLR;
        end else begin
            in_tgt = br_target_i;
        end
        // Traps go to a handler address the core trusts; only jumps/branches are checked.
        in_misal = in_vld & ~trap_i & (|(in_tgt & ALIGN_MASK));
        in_ok    = in_vld & ~in_misal;
    end

    // ------------------------------------------------------------------
    // Next-PC and pending-slot decision.
    // ------------------------------------------------------------------
    always_comb begin
        // BOOT behaves like a stall: nothing is applied, redirects are parked.
        hold          = ~in_run | stall_i;
        // A parked trap must survive any non-trap redirect, stalled or not.
        in_beats_pend = trap_i | ~(pend_q.vld & pend_q.trap);
        take_in       = ~hold & in_ok & in_beats_pend;
        take_pend     = ~hold & ~take_in & pend_q.vld;

        pc_nxt   = pc_q;
        pend_nxt = pend_q;

        if (hold) begin
            if (in_ok && in_beats_pend) begin
                pend_nxt.vld  = 1'b1;
                pend_nxt.trap = trap_i;
                pend_nxt.tgt  = in_tgt;
            end
        end else begin
            if (take_in) begin
                pc_nxt = in_tgt;
            end else if (take_pend) begin
                pc_nxt = pend_q.tgt;
            end else if (fetch_ready_i) begin
                // Natural XLEN-bit wrap from the top of the address space to 0.
                pc_nxt = pc_q + PC_INC;
            end
            // Any unstalled cycle either consumes the pending slot or finds it
            // superseded by a newer redirect, so it is always emptied here.
            pend_nxt.vld  = 1'b0;
            pend_nxt.trap = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            pend_q     <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            pc_q       <= pc_nxt;
            pend_q     <= pend_nxt;
            redirect_q <= take_in | take_pend;
            misalign_q <= in_misal;
            if (in_misal) begin
                bad_addr_q <= in_tgt;
            end
        end
    end

    assign pc_o       = pc_q;
    assign redirect_o = redirect_q;
    assign misalign_o = misalign_q;
    assign bad_addr_o = bad_addr_q;

`ifdef PC_GEN_PERF_EN
    // ------------------------------------------------------------------
    // Saturating perf counters.
    // ------------------------------------------------------------------
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (redirect_q && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            // Only RUN stalls count; the BOOT cycle is not a hazard stall.
            if (in_run && stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen_param.sv
// Bench for pc_gen_param: directed scenarios with fixed expectations, then randomized traffic vs. a behavioural model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).

module tb_pc_gen_param;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_1000;
    localparam int          IB   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        trap_i;
    logic [31:0] trap_vec_i;
    logic        fetch_ready_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        redirect_o;
    logic        misalign_o;
    logic [31:0] bad_addr_o;
`ifdef PC_GEN_PERF_EN
    logic [31:0] redirect_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen_param #(
        .XLEN        (XLEN),
        .RESET_VEC   (RV),
        .INSTR_BYTES (IB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .trap_i        (trap_i),
        .trap_vec_i    (trap_vec_i),
        .fetch_ready_i (fetch_ready_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .redirect_o    (redirect_o),
        .misalign_o    (misalign_o),
        .bad_addr_o    (bad_addr_o)
`ifdef PC_GEN_PERF_EN
        ,
        .redirect_cnt_o (redirect_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    // ------------------------------------------------------------------
    // Behavioural reference: what the fetch unit should look like after
    // each clock edge, given the inputs seen at that edge.
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    bit          m_running;
    bit          m_parked;
    bit          m_parked_is_trap;
    logic [31:0] m_parked_addr;
    bit          m_redirect;
    bit          m_misalign;
    logic [31:0] m_bad;
    logic [31:0] m_rcnt;
    logic [31:0] m_scnt;

    task automatic model_edge();
        bit          want;
        bit          is_trap;
        bit          dropped;
        bit          usable;
        logic [31:0] dest;
        if (reset) begin
            m_pc = RV; m_running = 0; m_parked = 0; m_parked_is_trap = 0;
            m_parked_addr = 0; m_redirect = 0; m_misalign = 0; m_bad = 0;
            m_rcnt = 0; m_scnt = 0;
            return;
        end
        want    = trap_i || jump_i || br_taken_i;
        is_trap = trap_i;
        if (trap_i)      dest = trap_vec_i;
        else if (jump_i) dest = jump_target_i - (jump_target_i % 2);
        else             dest = br_target_i;
        dropped = want && !is_trap && ((dest % IB) != 0);
        usable  = want && !dropped && (is_trap || !(m_parked && m_parked_is_trap));

        if (m_redirect && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 1;
        if (m_running && stall_i && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;

        m_misalign = dropped;
        if (dropped) m_bad = dest;

        m_redirect = 0;
        if (!m_running || stall_i) begin
            if (usable) begin
                m_parked = 1; m_parked_is_trap = is_trap; m_parked_addr = dest;
            end
            m_running = 1;
        end else begin
            if (usable) begin
                m_pc = dest; m_redirect = 1;
            end else if (m_parked) begin
                m_pc = m_parked_addr; m_redirect = 1;
            end else if (fetch_ready_i) begin
                m_pc = 32'((64'(m_pc) + 64'(IB)) % 64'h1_0000_0000);
            end
            m_parked = 0; m_parked_is_trap = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_req();
        br_taken_i = 0; jump_i = 0; trap_i = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1; stall_i = 0; fetch_ready_i = 0; clear_req();
        br_target_i = 0; jump_target_i = 0; trap_vec_i = 0;
        cyc(); cyc();
        n_checks++; if (pc_o !== RV) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_o, RV); end
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pc_valid_o); end
        n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
        n_checks++; if (bad_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_bad_addr: got %h want 0", bad_addr_o); end
`ifdef PC_GEN_PERF_EN
        n_checks++; if (redirect_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_rcnt: got %0d want 0", redirect_cnt_o); end
        n_checks++; if (stall_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_scnt: got %0d want 0", stall_cnt_o); end
`endif
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        reset = 0; fetch_ready_i = 1;
        #1;
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", pc_valid_o); end
        exp_pc = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_o, exp_pc); end
            n_checks++; if (pc_valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b want 1", i, pc_valid_o); end
            exp_pc = exp_pc + 4;
        end
    endtask

    task automatic test_backpressure();
        jump_i = 1; jump_target_i = 32'h20;
        cyc();
        clear_req();
        n_checks++; if (pc_o !== 32'h20) begin n_fail++; $display("FAIL bp_jump_pc: got %h want 20", pc_o); end
        n_checks++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL bp_jump_redirect: got %b want 1", redirect_o); end
        fetch_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (pc_o !== 32'h20) begin n_fail++; $display("FAIL bp_hold%0d: got %h want 20", i, pc_o); end
        end
        fetch_ready_i = 1;
        cyc();
        n_checks++; if (pc_o !== 32'h24) begin n_fail++; $display("FAIL bp_resume: got %h want 24", pc_o); end
    endtask

    task automatic test_priority();
        trap_i = 1; trap_vec_i = 32'h100;
        jump_i = 1; jump_target_i = 32'h200;
        br_taken_i = 1; br_target_i = 32'h300;
        cyc();
        clear_req();
        n_checks++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL prio_pc: got %h want 100", pc_o); end
        n_checks++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL prio_redirect: got %b want 1", redirect_o); end
        cyc();
        n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL prio_pulse_len: got %b want 0", redirect_o); end
        n_checks++; if (pc_o !== 32'h104) begin n_fail++; $display("FAIL prio_next_pc: got %h want 104", pc_o); end
    endtask

    task automatic test_stall_pending();
        stall_i = 1;
        for (int i = 1; i <= 4; i++) begin
            clear_req();
            if (i == 1) begin br_taken_i = 1; br_target_i = 32'h40; end
            if (i == 2) begin trap_i = 1; trap_vec_i = 32'h80; end
            if (i == 3) begin jump_i = 1; jump_target_i = 32'hC0; end
            cyc();
            n_checks++; if (pc_o !== 32'h104) begin n_fail++; $display("FAIL stall_hold%0d: got %h want 104", i, pc_o); end
            n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL stall_redirect%0d: got %b want 0", i, redirect_o); end
        end
        clear_req(); stall_i = 0;
        cyc();
        n_checks++; if (pc_o !== 32'h80) begin n_fail++; $display("FAIL stall_apply_pc: got %h want 80", pc_o); end
        n_checks++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL stall_apply_redirect: got %b want 1", redirect_o); end
        cyc();
        n_checks++; if (pc_o !== 32'h84) begin n_fail++; $display("FAIL stall_after_pc: got %h want 84", pc_o); end
    endtask

    task automatic test_misalign();
        jump_i = 1; jump_target_i = 32'h0000_0103;
        cyc();
        clear_req();
        n_checks++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misalign_o); end
        n_checks++; if (bad_addr_o !== 32'h102) begin n_fail++; $display("FAIL mis_bad_addr: got %h want 102", bad_addr_o); end
        n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL mis_no_redirect: got %b want 0", redirect_o); end
        n_checks++; if (pc_o !== 32'h88) begin n_fail++; $display("FAIL mis_seq_pc: got %h want 88", pc_o); end
        cyc();
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_len: got %b want 0", misalign_o); end
        n_checks++; if (bad_addr_o !== 32'h102) begin n_fail++; $display("FAIL mis_bad_hold: got %h want 102", bad_addr_o); end
        n_checks++; if (pc_o !== 32'h8C) begin n_fail++; $display("FAIL mis_seq_pc2: got %h want 8c", pc_o); end
    endtask

    task automatic test_wrap();
        jump_i = 1; jump_target_i = 32'hFFFF_FFFC;
        cyc();
        clear_req();
        n_checks++; if (pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want fffffffc", pc_o); end
        cyc();
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", pc_o); end
    endtask

    task automatic test_reset_mid_pending();
        stall_i = 1; br_taken_i = 1; br_target_i = 32'h200;
        cyc();
        clear_req();
        reset = 1;
        cyc();
        n_checks++; if (pc_o !== RV) begin n_fail++; $display("FAIL rst_pend_pc: got %h want %h", pc_o, RV); end
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_pend_valid: got %b want 0", pc_valid_o); end
`ifdef PC_GEN_PERF_EN
        n_checks++; if (redirect_cnt_o !== 32'h0) begin n_fail++; $display("FAIL rst_pend_rcnt: got %0d want 0", redirect_cnt_o); end
        n_checks++; if (stall_cnt_o !== 32'h0) begin n_fail++; $display("FAIL rst_pend_scnt: got %0d want 0", stall_cnt_o); end
`endif
        reset = 0; stall_i = 0;
        cyc();
        cyc();
        n_checks++; if (pc_o !== RV + 4) begin n_fail++; $display("FAIL rst_pend_not_applied: got %h want %h", pc_o, RV + 4); end
        n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL rst_pend_redirect: got %b want 0", redirect_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(99) == 0);
            stall_i       = ($urandom_range(3) == 0);
            fetch_ready_i = ($urandom_range(3) != 0);
            trap_i        = ($urandom_range(19) == 0);
            jump_i        = ($urandom_range(9) == 0);
            br_taken_i    = ($urandom_range(9) == 0);
            trap_vec_i    = $urandom;
            jump_target_i = $urandom;
            br_target_i   = $urandom;
            if ($urandom_range(3) != 0) jump_target_i = jump_target_i & 32'hFFFF_FFFC;
            if ($urandom_range(3) != 0) br_target_i   = br_target_i & 32'hFFFF_FFFC;
            cyc();
            n_checks++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc_o, m_pc); end
            n_checks++; if (pc_valid_o !== m_running) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, pc_valid_o, m_running); end
            n_checks++; if (redirect_o !== m_redirect) begin n_fail++; $display("FAIL rnd_redirect@%0d: got %b want %b", i, redirect_o, m_redirect); end
            n_checks++; if (misalign_o !== m_misalign) begin n_fail++; $display("FAIL rnd_misalign@%0d: got %b want %b", i, misalign_o, m_misalign); end
            n_checks++; if (bad_addr_o !== m_bad) begin n_fail++; $display("FAIL rnd_bad_addr@%0d: got %h want %h", i, bad_addr_o, m_bad); end
            n_checks++; if (redirect_o && misalign_o && !(stall_i === 1'b0)) begin n_fail++; $display("FAIL rnd_excl@%0d: got both pulses set while stalled", i); end
`ifdef PC_GEN_PERF_EN
            n_checks++; if (redirect_cnt_o !== m_rcnt) begin n_fail++; $display("FAIL rnd_rcnt@%0d: got %0d want %0d", i, redirect_cnt_o, m_rcnt); end
            n_checks++; if (stall_cnt_o !== m_scnt) begin n_fail++; $display("FAIL rnd_scnt@%0d: got %0d want %0d", i, stall_cnt_o, m_scnt); end
`endif
        end
        reset = 0; stall_i = 0; clear_req();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_priority();
        test_stall_pending();
        test_misalign();
        test_wrap();
        test_reset_mid_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
